// File: rtl/ascon_xor_down_out.sv
// rtl/ascon_xor_down_out.sv - ASCON XOR-down stage with buffered ciphertext and tag outputs
module ascon_xor_down_out #(
    parameter int CNT_W = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  init_i,
    input  logic [4:0][63:0]      state_i,
    input  logic [127:0]          key_i,
    input  logic                  ena_xor_down_i,
    input  logic                  ena_lsb_i,
    output logic [4:0][63:0]      state_o,
    input  logic                  cipher_en_i,
    output logic [127:0]          cipher_o,
    output logic                  cipher_valid_o,
    input  logic                  cipher_ready_i,
    input  logic                  tag_en_i,
    output logic [127:0]          tag_o,
    output logic                  tag_valid_o,
    input  logic                  tag_ready_i,
    output logic [CNT_W-1:0]      block_cnt_o,
    output logic                  overflow_o
);

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    buf_state_t cipher_state, cipher_state_next;
    buf_state_t tag_state, tag_state_next;
    logic       cipher_load, cipher_drop;
    logic       tag_load, tag_drop;

    always_comb begin
        state_o    = state_i;
        state_o[3] = state_i[3] ^ (ena_xor_down_i ? key_i[63:0] : 64'h0);
        state_o[4] = state_i[4] ^ (ena_xor_down_i ? key_i[127:64] : 64'h0)
                                 ^ (ena_lsb_i ? 64'h1 : 64'h0);
    end

    // A full buffer accepts a new block only when the consumer drains the old one in the same cycle.
    always_comb begin
        cipher_state_next = cipher_state;
        cipher_load       = 1'b0;
        cipher_drop       = 1'b0;
        case (cipher_state)
            BUF_EMPTY: begin
                if (cipher_en_i) begin
                    cipher_load       = 1'b1;
                    cipher_state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (cipher_ready_i) begin
                    if (cipher_en_i) cipher_load = 1'b1;
                    else             cipher_state_next = BUF_EMPTY;
                end else if (cipher_en_i) begin
                    cipher_drop = 1'b1;
                end
            end
            default: cipher_state_next = BUF_EMPTY;
        endcase
    end

    always_comb begin
        tag_state_next = tag_state;
        tag_load       = 1'b0;
        tag_drop       = 1'b0;
        case (tag_state)
            BUF_EMPTY: begin
                if (tag_en_i) begin
                    tag_load       = 1'b1;
                    tag_state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (tag_ready_i) begin
                    if (tag_en_i) tag_load = 1'b1;
                    else          tag_state_next = BUF_EMPTY;
                end else if (tag_en_i) begin
                    tag_drop = 1'b1;
                end
            end
            default: tag_state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cipher_state <= BUF_EMPTY;
            tag_state    <= BUF_EMPTY;
            cipher_o     <= '0;
            tag_o        <= '0;
            block_cnt_o  <= '0;
            overflow_o   <= 1'b0;
        end else if (init_i) begin
            cipher_state <= BUF_EMPTY;
            tag_state    <= BUF_EMPTY;
            cipher_o     <= '0;
            tag_o        <= '0;
            block_cnt_o  <= '0;
            overflow_o   <= 1'b0;
        end else begin
            cipher_state <= cipher_state_next;
            tag_state    <= tag_state_next;
            if (cipher_load) begin
                cipher_o <= {state_i[1], state_i[0]};
                if (block_cnt_o != CNT_MAX) block_cnt_o <= block_cnt_o + CNT_W'(1);
            end
            if (tag_load) tag_o <= {state_o[4], state_o[3]};
            if (cipher_drop || tag_drop) overflow_o <= 1'b1;
        end
    end

    assign cipher_valid_o = (cipher_state == BUF_FULL);
    assign tag_valid_o    = (tag_state == BUF_FULL);

endmodule
